m_dsrca: RTL
============

M_DSRCA -- requirements
Module: m_dsrca

Interface
REQ-001 Parameter N, default 8: operand width in bits.
REQ-002 Parameter D, default 2: digit width, i.e. bits processed per cycle; N mod D SHALL be 0, otherwise elaboration fails.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand shares and mode present.
REQ-006 in_ready  output  1  block can accept; high only in IDLE.
REQ-007 sub  input  1  0: a+b; 1: a-b; sampled on accept.
REQ-008 a0, a1, b0, b1  input  N each  Boolean shares; a = a0^a1, b = b0^b1.
REQ-009 rnd  input  2*D  fresh random bits consumed every RUN cycle.
REQ-010 out_valid  output  1  result shares valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum0, sum1  output  N+1 each  result shares; sum0^sum1 = {carry_out, result}.

Function
REQ-013 FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE to RUN on in_valid&&in_ready; operand shares and sub are registered, digit counter = 0.
REQ-015 On accept, carry share0 = sub, carry share1 = 0; for sub=1, b0 SHALL be stored inverted (b1 untouched).
REQ-016 RUN processes digit k (bits k*D .. k*D+D-1, LSB first) in cycle k+1 after accept; N/D RUN cycles total.
REQ-017 Per bit: s shares = a_i^b_i^c_i computed share-wise; c_out = (a&b) ^ (c&(a^b)) using two masked AND gadgets, each consuming one rnd bit.
REQ-018 Digit k result shares written into sum0/sum1 bits k*D+D-1..k*D; the carry shares are registered between digits.
REQ-019 RUN to DONE after digit N/D-1; the final carry shares are written to sum0[N]/sum1[N].
REQ-020 out_valid SHALL be high exactly in DONE: first assertion N/D+1 cycles after the accept edge.
REQ-021 DONE to IDLE on out_ready; sum0/sum1 SHALL hold stable while out_valid && !out_ready.
REQ-022 in_valid during RUN/DONE SHALL be ignored (in_ready=0); no operand capture.
REQ-023 No unmasked value of a, b, carry or sum SHALL be stored in any register; shares are never recombined inside the block.
REQ-024 Arithmetic is modulo 2^(N+1) on the concatenation; for sub=1, bit N = 1 means no borrow (a >= b).
REQ-025 rnd is ignored outside RUN.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, out_valid=0, sum0=sum1=0, carry shares=0, digit counter=0; in_ready=1.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no residual output; the next accept starts cleanly.

Structure
REQ-028 Package m_dsrca_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the N/D divisibility check function.
REQ-029 Sub-module m_fa_dom: one masked full adder bit (inputs: a, b and c shares, 2 rnd bits; outputs: s and c_out shares); instantiated D times in a chain.

Verification
REQ-030 N=8, D=2, sub=0, a0=0x3C a1=0x66 (a=0x5A), b0=0x81 b1=0x42 (b=0xC3) -> out_valid 5 cycles after accept, sum0^sum1=0x11D.
REQ-031 Same shares, sub=1 -> sum0^sum1=0x097 (bit8=0: borrow).
REQ-032 a=0xFF, b=0xFF with random share splits, 1000 random rnd streams -> always 0x1FE; sum0 alone is not constant across runs.
REQ-033 out_ready held low 5 cycles in DONE, in_valid pulsed meanwhile -> sum shares unchanged, in_ready=0, no capture; IDLE one cycle after out_ready=1.
REQ-034 rst_n pulsed low in the 2nd RUN cycle -> out_valid=0, sums=0 immediately; the following operation 0x01+0x01 -> 0x002.
REQ-035 Random regression, N=16, D=4, mixed sub -> sum0^sum1 matches the reference model; latency = 5 cycles every time.

Source files
------------

// File: rtl/m_dsrca_pkg.sv
// Shared types and elaboration helpers for the masked digit-serial
// ripple-carry adder/subtractor.
package m_dsrca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit f_div_ok(input int unsigned n, input int unsigned d);
        return (d != 0) && ((n % d) == 0);
    endfunction

endpackage

// File: rtl/m_dsrca_if.sv
// Operand/result handshake bundle: two Boolean shares per operand and result.
interface m_dsrca_if #(
    parameter int unsigned N = 8,
    parameter int unsigned D = 2
);
    logic             in_valid;
    logic             in_ready;
    logic             sub;
    logic [N-1:0]     a0;
    logic [N-1:0]     a1;
    logic [N-1:0]     b0;
    logic [N-1:0]     b1;
    logic [2*D-1:0]   rnd;
    logic             out_valid;
    logic             out_ready;
    logic [N:0]       sum0;
    logic [N:0]       sum1;

    modport master (
        output in_valid, sub, a0, a1, b0, b1, rnd, out_ready,
        input  in_ready, out_valid, sum0, sum1
    );

    modport slave (
        input  in_valid, sub, a0, a1, b0, b1, rnd, out_ready,
        output in_ready, out_valid, sum0, sum1
    );
endinterface

// File: rtl/m_dsrca_fa_dom.sv
// One masked full-adder bit: share-wise XOR sum, carry built from two
// domain-oriented masked AND gadgets each refreshed by one random bit.
module m_fa_dom (
    input  logic       i_a0,
    input  logic       i_a1,
    input  logic       i_b0,
    input  logic       i_b1,
    input  logic       i_c0,
    input  logic       i_c1,
    input  logic [1:0] i_rnd,
    output logic       o_s0,
    output logic       o_s1,
    output logic       o_c0,
    output logic       o_c1
);
    logic w_p0, w_p1;
    logic w_g0, w_g1;
    logic w_h0, w_h1;

    assign w_p0 = i_a0 ^ i_b0;
    assign w_p1 = i_a1 ^ i_b1;
    assign o_s0 = w_p0 ^ i_c0;
    assign o_s1 = w_p1 ^ i_c1;

    // Cross-domain products are masked before they meet the other domain.
    assign w_g0 = (i_a0 & i_b0) ^ ((i_a0 & i_b1) ^ i_rnd[0]);
    assign w_g1 = (i_a1 & i_b1) ^ ((i_a1 & i_b0) ^ i_rnd[0]);
    assign w_h0 = (i_c0 & w_p0) ^ ((i_c0 & w_p1) ^ i_rnd[1]);
    assign w_h1 = (i_c1 & w_p1) ^ ((i_c1 & w_p0) ^ i_rnd[1]);

    assign o_c0 = w_g0 ^ w_h0;
    assign o_c1 = w_g1 ^ w_h1;
endmodule

// File: rtl/m_dsrca.sv
// Masked digit-serial add/subtract: D bits per RUN cycle through a chain of
// m_fa_dom cells, carry shares registered between digits.
module m_dsrca
    import m_dsrca_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned D = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    m_dsrca_if.slave      io_bus
);
    localparam int unsigned NDIG = N / D;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!f_div_ok(N, D)) begin : g_bad_digit
        $fatal(1, "m_dsrca: N must be a multiple of D");
    end

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a0, r_a1, r_b0, r_b1;
    logic           r_c0, r_c1;
    logic [N:0]     r_sum0, r_sum1;

    logic [D:0]     w_c0, w_c1;
    logic [D-1:0]   w_s0, w_s1;

    assign w_c0[0] = r_c0;
    assign w_c1[0] = r_c1;

    // Operand shares shift right each digit so the active digit is always bits D-1..0.
    for (genvar i = 0; i < D; i++) begin : g_fa
        m_fa_dom u_fa (
            .i_a0  (r_a0[i]),
            .i_a1  (r_a1[i]),
            .i_b0  (r_b0[i]),
            .i_b1  (r_b1[i]),
            .i_c0  (w_c0[i]),
            .i_c1  (w_c1[i]),
            .i_rnd (io_bus.rnd[2*i +: 2]),
            .o_s0  (w_s0[i]),
            .o_s1  (w_s1[i]),
            .o_c0  (w_c0[i+1]),
            .o_c1  (w_c1[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_b0    <= '0;
            r_b1    <= '0;
            r_c0    <= 1'b0;
            r_c1    <= 1'b0;
            r_sum0  <= '0;
            r_sum1  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_a0    <= io_bus.a0;
                        r_a1    <= io_bus.a1;
                        r_b0    <= io_bus.sub ? ~io_bus.b0 : io_bus.b0;
                        r_b1    <= io_bus.b1;
                        r_c0    <= io_bus.sub;
                        r_c1    <= 1'b0;
                        r_cnt   <= '0;
                        r_sum0  <= '0;
                        r_sum1  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a0  <= r_a0 >> D;
                    r_a1  <= r_a1 >> D;
                    r_b0  <= r_b0 >> D;
                    r_b1  <= r_b1 >> D;
                    r_c0  <= w_c0[D];
                    r_c1  <= w_c1[D];
                    r_cnt <= r_cnt + 1'b1;
                    for (int unsigned k = 0; k < NDIG; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_sum0[k*D +: D] <= w_s0;
                            r_sum1[k*D +: D] <= w_s1;
                        end
                    end
                    if (r_cnt == CW'(NDIG - 1)) begin
                        r_sum0[N] <= w_c0[D];
                        r_sum1[N] <= w_c1[D];
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == IDLE);
    assign io_bus.out_valid = (r_state == DONE);
    assign io_bus.sum0      = r_sum0;
    assign io_bus.sum1      = r_sum1;
endmodule
